// File: rtl/ingress_retire_packer_pkg.sv
// Shared types and defaults for the multi-retire ingress trace packer.
package ingress_retire_packer_pkg;

    localparam int unsigned NRET_DEF        = 2;
    localparam int unsigned XLEN_DEF        = 64;
    localparam int unsigned IRETIRE_LEN_DEF = 32;
    localparam int unsigned ITYPE_LEN_DEF   = 3;
    localparam int unsigned CAUSE_LEN_DEF   = 5;
    localparam int unsigned PRIV_LEN_DEF    = 2;
    localparam int unsigned OUT_DEPTH_DEF   = 4;

    localparam int unsigned ITYPE_STD = 0;
    localparam int unsigned ITYPE_EXC = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    // Pointer width that stays at least one bit for degenerate depths.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/ingress_block_fifo.sv
// Block FIFO with NPUSH in-order push ports, one pop port and a registered free count.
module ingress_block_fifo
    import ingress_retire_packer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NPUSH = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NPUSH-1:0]            push_i,
    input  logic [NPUSH*WIDTH-1:0]      push_data_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            head_o,
    output logic                        empty_o,
    output logic [clog2_min1(DEPTH):0]  free_o
);

    localparam int unsigned PTR_W = clog2_min1(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] slot [NPUSH];
    logic             do_pop;
    int unsigned      npush;

    // Sparse push lanes are packed into consecutive slots, keeping lane order.
    always_comb begin
        npush = 0;
        for (int k = 0; k < NPUSH; k++) begin
            slot[k] = PTR_W'((32'(wr_ptr_q) + npush) % DEPTH);
            if (push_i[k]) begin
                npush = npush + 1;
            end
        end
        do_pop   = pop_i && (cnt_q != '0);
        wr_ptr_d = PTR_W'((32'(wr_ptr_q) + npush) % DEPTH);
        rd_ptr_d = do_pop ? PTR_W'((32'(rd_ptr_q) + 1) % DEPTH) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(npush) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NPUSH; k++) begin
            if (push_i[k]) begin
                mem_q[slot[k]] <= push_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign free_o  = CNT_W'(DEPTH) - cnt_q;

endmodule

// File: rtl/ingress_retire_packer.sv
// Packs up to NRET committed instructions per cycle into trace blocks for the encoder.
module ingress_retire_packer
    import ingress_retire_packer_pkg::*;
#(
    parameter int unsigned NRET        = NRET_DEF,
    parameter int unsigned XLEN        = XLEN_DEF,
    parameter int unsigned IRETIRE_LEN = IRETIRE_LEN_DEF,
    parameter int unsigned ITYPE_LEN   = ITYPE_LEN_DEF,
    parameter int unsigned CAUSE_LEN   = CAUSE_LEN_DEF,
    parameter int unsigned PRIV_LEN    = PRIV_LEN_DEF,
    parameter int unsigned OUT_DEPTH   = OUT_DEPTH_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NRET-1:0]           valid_i,
    input  logic [NRET*XLEN-1:0]      pc_i,
    input  logic [NRET*ITYPE_LEN-1:0] itype_i,
    input  logic [NRET-1:0]           compressed_i,
    input  logic [NRET*CAUSE_LEN-1:0] cause_i,
    input  logic [NRET*XLEN-1:0]      tval_i,
    input  logic [NRET*PRIV_LEN-1:0]  priv_i,
    output logic                      ready_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [XLEN-1:0]           iaddr_o,
    output logic [IRETIRE_LEN-1:0]    iretire_o,
    output logic                      ilastsize_o,
    output logic [ITYPE_LEN-1:0]      itype_o,
    output logic [CAUSE_LEN-1:0]      cause_o,
    output logic [XLEN-1:0]           tval_o,
    output logic [PRIV_LEN-1:0]       priv_o
);

    typedef struct packed {
        logic [XLEN-1:0]        iaddr;
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
    } blk_t;

    localparam int unsigned BLK_W  = $bits(blk_t);
    localparam int unsigned FREE_W = clog2_min1(OUT_DEPTH) + 1;
    localparam int unsigned NV     = NRET + 1;
    // Close threshold 2^IRETIRE_LEN-2 keeps count+2 inside the counter.
    localparam logic [IRETIRE_LEN-1:0] SAT = {{(IRETIRE_LEN-1){1'b1}}, 1'b0};

    state_e                 state_q, state_d;
    logic [IRETIRE_LEN-1:0] count_q, count_d;
    logic [XLEN-1:0]        iaddr_q, iaddr_d;

    logic [NRET-1:0]        push;
    logic [NRET*BLK_W-1:0]  push_data;
    logic [BLK_W-1:0]       head_raw;
    blk_t                   head;
    logic                   empty;
    logic [FREE_W-1:0]      free;

    blk_t                   blk;
    logic                   blk_open;
    logic [IRETIRE_LEN-1:0] cnt;
    logic [IRETIRE_LEN-1:0] sz;
    logic [XLEN-1:0]        addr;
    logic [ITYPE_LEN-1:0]   it;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            iaddr_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            iaddr_q <= iaddr_d;
        end
    end

    // Lane chain: each accepted lane updates open/count/iaddr and may close one block.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        iaddr_d   = iaddr_q;
        push      = '0;
        push_data = '0;
        blk       = '0;
        sz        = '0;
        it        = '0;
        blk_open  = (state_q == COUNT);
        cnt       = count_q;
        addr      = iaddr_q;
        for (int k = 0; k < NRET; k++) begin
            if (ready_o && valid_i[k]) begin
                it = itype_i[k*ITYPE_LEN +: ITYPE_LEN];
                sz = compressed_i[k] ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
                if (!blk_open) begin
                    addr     = pc_i[k*XLEN +: XLEN];
                    cnt      = sz;
                    blk_open = 1'b1;
                end else begin
                    cnt = cnt + sz;
                end
                blk.iaddr     = addr;
                blk.iretire   = cnt;
                blk.ilastsize = !compressed_i[k];
                blk.itype     = it;
                blk.cause     = cause_i[k*CAUSE_LEN +: CAUSE_LEN];
                blk.tval      = tval_i[k*XLEN +: XLEN];
                blk.priv      = priv_i[k*PRIV_LEN +: PRIV_LEN];
                if (it != ITYPE_LEN'(ITYPE_STD)) begin
                    push[k]  = 1'b1;
                    blk_open = 1'b0;
                end else if (cnt >= SAT) begin
                    blk.itype = ITYPE_LEN'(ITYPE_STD);
                    push[k]   = 1'b1;
                    blk_open  = 1'b0;
                end
                push_data[k*BLK_W +: BLK_W] = blk;
            end
        end
        state_d = blk_open ? COUNT : IDLE;
        count_d = blk_open ? cnt : '0;
        iaddr_d = addr;
    end

    ingress_block_fifo #(
        .WIDTH (BLK_W),
        .DEPTH (OUT_DEPTH),
        .NPUSH (NRET)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (ready_i),
        .head_o      (head_raw),
        .empty_o     (empty),
        .free_o      (free)
    );

    assign ready_o = (free >= FREE_W'(NRET));
    assign valid_o = !empty;
    assign head    = empty ? '0 : blk_t'(head_raw);

    assign iaddr_o     = head.iaddr;
    assign iretire_o   = head.iretire;
    assign ilastsize_o = head.ilastsize;
    assign itype_o     = head.itype;
    assign cause_o     = head.cause;
    assign tval_o      = head.tval;
    assign priv_o      = head.priv;

    // Valid lanes must be contiguous from lane 0.
    logic [NV-1:0] vnext;
    assign vnext = {1'b0, valid_i} + NV'(1);
    assert property (@(posedge clk_i) disable iff (rst_i) ((vnext & {1'b0, valid_i}) == '0));

endmodule

// File: tb/tb_ingress_retire_packer.sv
// Directed table-driven bench for ingress_retire_packer (NRET=2, IRETIRE_LEN=4, depth 4).
module tb_ingress_retire_packer;

    localparam int unsigned NRET  = 2;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned IRL   = 4;
    localparam int unsigned ITL   = 3;
    localparam int unsigned CL    = 5;
    localparam int unsigned PL    = 2;
    localparam int unsigned DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic [NRET-1:0]      valid_i;
    logic [NRET*XLEN-1:0] pc_i;
    logic [NRET*ITL-1:0]  itype_i;
    logic [NRET-1:0]      compressed_i;
    logic [NRET*CL-1:0]   cause_i;
    logic [NRET*XLEN-1:0] tval_i;
    logic [NRET*PL-1:0]   priv_i;
    logic                 ready_o, valid_o, ready_i;
    logic [XLEN-1:0]      iaddr_o, tval_o;
    logic [IRL-1:0]       iretire_o;
    logic                 ilastsize_o;
    logic [ITL-1:0]       itype_o;
    logic [CL-1:0]        cause_o;
    logic [PL-1:0]        priv_o;

    always #5 clk = ~clk;

    ingress_retire_packer #(
        .NRET(NRET), .XLEN(XLEN), .IRETIRE_LEN(IRL), .ITYPE_LEN(ITL),
        .CAUSE_LEN(CL), .PRIV_LEN(PL), .OUT_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i),
        .itype_i(itype_i), .compressed_i(compressed_i), .cause_i(cause_i),
        .tval_i(tval_i), .priv_i(priv_i), .ready_o(ready_o), .valid_o(valid_o),
        .ready_i(ready_i), .iaddr_o(iaddr_o), .iretire_o(iretire_o),
        .ilastsize_o(ilastsize_o), .itype_o(itype_o), .cause_o(cause_o),
        .tval_o(tval_o), .priv_o(priv_o)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  cmp;
        logic [63:0] pc0, pc1;
        logic [2:0]  it0, it1;
        logic [4:0]  ca0, ca1;
        logic        exp_v;
    } in_t;

    int passed = 0;
    int checks = 0;
    logic [78:0] got[$];

    function automatic in_t mk(input logic [1:0] v, input logic [1:0] c,
                               input logic [63:0] p0, input logic [2:0] t0, input logic [4:0] a0,
                               input logic [63:0] p1, input logic [2:0] t1, input logic [4:0] a1,
                               input logic ev);
        in_t r;
        r.valid = v; r.cmp = c; r.pc0 = p0; r.it0 = t0; r.ca0 = a0;
        r.pc1 = p1; r.it1 = t1; r.ca1 = a1; r.exp_v = ev;
        return r;
    endfunction

    function automatic logic [78:0] ex(input logic [63:0] a, input logic [3:0] r, input logic l,
                                       input logic [2:0] t, input logic [4:0] c, input logic [1:0] p);
        return {a, r, l, t, c, p};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Capture every block that is popped at the next rising edge.
    always @(negedge clk) begin
        if (!rst_i && valid_o && ready_i)
            got.push_back({iaddr_o, iretire_o, ilastsize_o, itype_o, cause_o, priv_o});
    end

    // Called at posedge+1; holds lanes until ready_o, returns at posedge+1 after acceptance.
    task automatic apply(input in_t x);
        int n;
        valid_i      = x.valid;
        compressed_i = x.cmp;
        pc_i         = {x.pc1, x.pc0};
        itype_i      = {x.it1, x.it0};
        cause_i      = {x.ca1, x.ca0};
        tval_i       = {x.pc1 ^ 64'hF000, x.pc0 ^ 64'hF000};
        priv_i       = {2'd1, 2'd3};
        n = 0;
        while (!ready_o && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_accept", 128'(ready_o), 128'(1));
        @(posedge clk); #1;
        valid_i = '0;
    endtask

    task automatic wait_got(input int n);
        int c;
        c = 0;
        while (got.size() < n && c < 60) begin
            @(posedge clk); #1;
            c++;
        end
        chk("block_count", 128'(got.size()), 128'(n));
    endtask

    task automatic cmp_blocks(input string nm, input logic [78:0] e[$]);
        for (int i = 0; i < e.size(); i++)
            chk(nm, (i < got.size()) ? 128'(got[i]) : {128{1'b1}}, 128'(e[i]));
        got.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_t         tv[$];
        logic [78:0] ev[$];

        rst_i = 1'b1; ready_i = 1'b1; valid_i = '0; pc_i = '0; itype_i = '0;
        compressed_i = '0; cause_i = '0; tval_i = '0; priv_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        // Reset state and idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_valid_o", 128'(valid_o), 128'(0));
            chk("idle_ready_o", 128'(ready_o), 128'(1));
        end
        chk("idle_data", 128'({iaddr_o, iretire_o, ilastsize_o, itype_o, cause_o, priv_o}), 128'(0));
        chk("idle_tval", 128'(tval_o), 128'(0));
        @(posedge clk); #1;

        // Table: basic block, dual special, saturation, reopen at 0x1C
        tv.push_back(mk(2'b11, 2'b10, 64'h100, 3'd0, 5'd0, 64'h104, 3'd0, 5'd0, 1'b0));
        tv.push_back(mk(2'b01, 2'b00, 64'h106, 3'd2, 5'd0, 64'h0,   3'd0, 5'd0, 1'b1));
        tv.push_back(mk(2'b11, 2'b01, 64'h200, 3'd1, 5'd2, 64'h202, 3'd3, 5'd0, 1'b1));
        tv.push_back(mk(2'b11, 2'b00, 64'h0,   3'd0, 5'd0, 64'h4,   3'd0, 5'd0, 1'b1));
        tv.push_back(mk(2'b11, 2'b00, 64'h8,   3'd0, 5'd0, 64'hC,   3'd0, 5'd0, 1'b0));
        tv.push_back(mk(2'b11, 2'b00, 64'h10,  3'd0, 5'd0, 64'h14,  3'd0, 5'd0, 1'b0));
        tv.push_back(mk(2'b11, 2'b00, 64'h18,  3'd0, 5'd0, 64'h1C,  3'd0, 5'd0, 1'b1));
        tv.push_back(mk(2'b01, 2'b00, 64'h20,  3'd2, 5'd0, 64'h0,   3'd0, 5'd0, 1'b1));
        ev.push_back(ex(64'h100, 4'd5,  1'b1, 3'd2, 5'd0, 2'd3));
        ev.push_back(ex(64'h200, 4'd1,  1'b0, 3'd1, 5'd2, 2'd3));
        ev.push_back(ex(64'h202, 4'd2,  1'b1, 3'd3, 5'd0, 2'd1));
        ev.push_back(ex(64'h0,   4'd14, 1'b1, 3'd0, 5'd0, 2'd3));
        ev.push_back(ex(64'h1C,  4'd4,  1'b1, 3'd2, 5'd0, 2'd3));
        for (int i = 0; i < tv.size(); i++) begin
            apply(tv[i]);
            chk("valid_o_after_row", 128'(valid_o), 128'(tv[i].exp_v));
        end
        wait_got(ev.size());
        cmp_blocks("table_block", ev);

        // Backpressure: fill FIFO with specials, then release
        tv.delete(); ev.delete();
        ready_i = 1'b0;
        tv.push_back(mk(2'b11, 2'b11, 64'h300, 3'd4, 5'd0, 64'h302, 3'd4, 5'd0, 1'b1));
        tv.push_back(mk(2'b11, 2'b11, 64'h304, 3'd4, 5'd0, 64'h306, 3'd4, 5'd0, 1'b1));
        tv.push_back(mk(2'b11, 2'b11, 64'h308, 3'd4, 5'd0, 64'h30A, 3'd4, 5'd0, 1'b1));
        for (int i = 0; i < 6; i++)
            ev.push_back(ex(64'h300 + 64'(2 * i), 4'd1, 1'b0, 3'd4, 5'd0, (i % 2 == 0) ? 2'd3 : 2'd1));
        apply(tv[0]);
        chk("bp_ready_half", 128'(ready_o), 128'(1));
        apply(tv[1]);
        chk("bp_ready_full", 128'(ready_o), 128'(0));
        fork
            apply(tv[2]);
            begin
                for (int i = 0; i < 3; i++) begin
                    chk("bp_head_stable", 128'({valid_o, iaddr_o}), 128'({1'b1, 64'h300}));
                    @(posedge clk); #1;
                end
                ready_i = 1'b1;
            end
        join
        wait_got(ev.size());
        cmp_blocks("bp_block", ev);

        // Mid-block reset with two blocks queued
        tv.delete(); ev.delete();
        ready_i = 1'b0;
        apply(mk(2'b11, 2'b11, 64'h500, 3'd4, 5'd0, 64'h502, 3'd4, 5'd0, 1'b1));
        apply(mk(2'b11, 2'b00, 64'h400, 3'd0, 5'd0, 64'h404, 3'd0, 5'd0, 1'b1));
        apply(mk(2'b01, 2'b00, 64'h408, 3'd0, 5'd0, 64'h0,   3'd0, 5'd0, 1'b1));
        chk("pre_reset_valid", 128'(valid_o), 128'(1));
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        chk("post_reset_valid", 128'(valid_o), 128'(0));
        chk("post_reset_ready", 128'(ready_o), 128'(1));
        ready_i = 1'b1;
        ev.push_back(ex(64'h600, 4'd4, 1'b1, 3'd2, 5'd0, 2'd1));
        apply(mk(2'b11, 2'b00, 64'h600, 3'd0, 5'd0, 64'h604, 3'd2, 5'd0, 1'b1));
        wait_got(ev.size());
        cmp_blocks("reset_block", ev);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
